// File: rtl/vga_box_renderer.sv
// Bouncing-box overlay for a 640x480 VGA stream: a two-stage pixel pipeline
// plus a once-per-frame motion state machine that moves and recolours the box.
module vga_box_renderer #(
  parameter int unsigned BOX_SIZE = 32,
  parameter int unsigned STEP     = 1,
  parameter logic [11:0] BG_COLOR = 12'h000,
  // Entry 0 sits in the least-significant 12 bits: F80, 0F0, 08F, FFF.
  parameter logic [47:0] PALETTE  = {12'hFFF, 12'h08F, 12'h0F0, 12'hF80}
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       hsync_in,
  input  logic       vsync_in,
  input  logic       blanking_in,
  input  logic [9:0] x,
  input  logic [8:0] y,
  input  logic       en,
  output logic [3:0] vga_r,
  output logic [3:0] vga_g,
  output logic [3:0] vga_b,
  output logic       hsync_out,
  output logic       vsync_out,
  output logic       frame_tick,
  output logic [7:0] bounce_count
);

  typedef enum logic [1:0] {DR, DL, UR, UL} state_e;

  localparam logic [10:0] BOX_W    = 11'(BOX_SIZE);
  localparam logic [10:0] STEP_W   = 11'(STEP);
  localparam logic [10:0] H_ACTIVE = 11'd640;
  localparam logic [10:0] V_ACTIVE = 11'd480;
  localparam logic [10:0] X_MAX    = H_ACTIVE - BOX_W;
  localparam logic [10:0] Y_MAX    = V_ACTIVE - BOX_W;

  state_e      state_q, state_d;
  logic [9:0]  box_x_q, box_x_d;
  logic [8:0]  box_y_q, box_y_d;
  logic [1:0]  color_idx_q, color_idx_d;
  logic [7:0]  bounce_cnt_q, bounce_cnt_d;
  logic        vs_hist_q, vs_hist_d;
  logic        frame_tick_q, frame_tick_d;
  logic        hs1_q, hs1_d, vs1_q, vs1_d, blank1_q, blank1_d, in_box1_q, in_box1_d;
  logic        hs2_q, hs2_d, vs2_q, vs2_d;
  logic [11:0] rgb_q, rgb_d;

  logic [10:0] bx, by, x_next, y_next;
  logic        move_right, move_down, bounce_x, bounce_y, right_n, down_n;
  logic [11:0] box_color;

  assign bx = {1'b0, box_x_q};
  assign by = {2'b00, box_y_q};

  // Pixel pipeline: stage 1 decides membership, stage 2 resolves the colour.
  always_comb begin
    hs1_d     = hsync_in;
    vs1_d     = vsync_in;
    blank1_d  = blanking_in;
    in_box1_d = ({1'b0, x} >= bx) && ({1'b0, x} < bx + BOX_W) &&
                ({2'b00, y} >= by) && ({2'b00, y} < by + BOX_W);
    hs2_d     = hs1_q;
    vs2_d     = vs1_q;
    unique case (color_idx_q)
      2'd0:    box_color = PALETTE[11:0];
      2'd1:    box_color = PALETTE[23:12];
      2'd2:    box_color = PALETTE[35:24];
      default: box_color = PALETTE[47:36];
    endcase
    if (blank1_q)       rgb_d = 12'h000;
    else if (in_box1_q) rgb_d = box_color;
    else                rgb_d = BG_COLOR;
    vs_hist_d    = vsync_in;
    frame_tick_d = vs_hist_q & ~vsync_in;
  end

  // Motion: both axes are evaluated every cycle but only committed on an
  // enabled frame tick; a corner flips both directions as a single bounce.
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    state_d      = state_q;
    box_x_d      = box_x_q;
    box_y_d      = box_y_q;
    color_idx_d  = color_idx_q;
    bounce_cnt_d = bounce_cnt_q;
    move_right   = (state_q == DR) || (state_q == UR);
    move_down    = (state_q == DR) || (state_q == DL);
    bounce_x     = 1'b0;
    bounce_y     = 1'b0;

    if (move_right) begin
      if (bx + BOX_W + STEP_W > H_ACTIVE) begin
        x_next   = X_MAX;
        bounce_x = 1'b1;
      end else begin
        x_next = bx + STEP_W;
      end
    end else if (bx < STEP_W) begin
      x_next   = 11'd0;
      bounce_x = 1'b1;
    end else begin
      x_next = bx - STEP_W;
    end

    if (move_down) begin
      if (by + BOX_W + STEP_W > V_ACTIVE) begin
        y_next   = Y_MAX;
        bounce_y = 1'b1;
      end else begin
        y_next = by + STEP_W;
      end
    end else if (by < STEP_W) begin
      y_next   = 11'd0;
      bounce_y = 1'b1;
    end else begin
      y_next = by - STEP_W;
    end

    right_n = move_right ^ bounce_x;
    down_n  = move_down ^ bounce_y;

    if (frame_tick_q && en) begin
      box_x_d = x_next[9:0];
      box_y_d = y_next[8:0];
      unique case ({down_n, right_n})
        2'b11:   state_d = DR;
        2'b10:   state_d = DL;
        2'b01:   state_d = UR;
        default: state_d = UL;
      endcase
      if (bounce_x || bounce_y) begin
        bounce_cnt_d = bounce_cnt_q + 8'd1;
        color_idx_d  = color_idx_q + 2'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      state_q      <= DR;
      box_x_q      <= '0;
      box_y_q      <= '0;
      color_idx_q  <= '0;
      bounce_cnt_q <= '0;
      vs_hist_q    <= 1'b1;
      frame_tick_q <= 1'b0;
      hs1_q        <= 1'b1;
      vs1_q        <= 1'b1;
      blank1_q     <= 1'b1;
      in_box1_q    <= 1'b0;
      hs2_q        <= 1'b1;
      vs2_q        <= 1'b1;
      rgb_q        <= '0;
    end else begin
      state_q      <= state_d;
      box_x_q      <= box_x_d;
      box_y_q      <= box_y_d;
      color_idx_q  <= color_idx_d;
      bounce_cnt_q <= bounce_cnt_d;
      vs_hist_q    <= vs_hist_d;
      frame_tick_q <= frame_tick_d;
      hs1_q        <= hs1_d;
      vs1_q        <= vs1_d;
      blank1_q     <= blank1_d;
      in_box1_q    <= in_box1_d;
      hs2_q        <= hs2_d;
      vs2_q        <= vs2_d;
      rgb_q        <= rgb_d;
    end
  end

  assign vga_r        = rgb_q[11:8];
  assign vga_g        = rgb_q[7:4];
  assign vga_b        = rgb_q[3:0];
  assign hsync_out    = hs2_q;
  assign vsync_out    = vs2_q;
  assign frame_tick   = frame_tick_q;
  assign bounce_count = bounce_cnt_q;

endmodule

// File: tb/tb_vga_box_renderer.sv
// Directed bench for vga_box_renderer: pipeline alignment, colour selection,
// frame-tick edge detection, bounces (edge and corner) and mid-line reset.
module tb_vga_box_renderer;

  logic       clk = 1'b0;
  logic       rst, hsync_in, vsync_in, blanking_in, en;
  logic [9:0] x;
  logic [8:0] y;

  logic [3:0] a_r, a_g, a_b, c_r, c_g, c_b;
  logic       a_hs, a_vs, a_ft, c_hs, c_vs, c_ft;
  logic [7:0] a_cnt, c_cnt;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Default motion parameters, distinct background so it differs from blanking.
  vga_box_renderer #(.BG_COLOR(12'h123)) u_dut (
    .clk(clk), .rst(rst), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .blanking_in(blanking_in), .x(x), .y(y), .en(en),
    .vga_r(a_r), .vga_g(a_g), .vga_b(a_b), .hsync_out(a_hs), .vsync_out(a_vs),
    .frame_tick(a_ft), .bounce_count(a_cnt));

  // Large fast box: first corner bounce (DR at 400,240) lands on tick 459.
  vga_box_renderer #(.BOX_SIZE(240), .STEP(15)) u_corner (
    .clk(clk), .rst(rst), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .blanking_in(blanking_in), .x(x), .y(y), .en(en),
    .vga_r(c_r), .vga_g(c_g), .vga_b(c_b), .hsync_out(c_hs), .vsync_out(c_vs),
    .frame_tick(c_ft), .bounce_count(c_cnt));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One vsync falling edge; frame_tick is high in the cycle after the 0 is sampled.
  task automatic do_tick(input bit chk);
    vsync_in = 1'b1;
    step();
    vsync_in = 1'b0;
    step();
    if (chk) check("ft_pulse", a_ft, 1'b1);
    step();
    if (chk) check("ft_single", a_ft, 1'b0);
  endtask

  task automatic pixel(input logic [9:0] px, input logic [8:0] py, input logic blank);
    x = px;
    y = py;
    blanking_in = blank;
    step();
    step();
  endtask

  initial begin
    rst = 1'b1; hsync_in = 1'b1; vsync_in = 1'b1; blanking_in = 1'b1;
    en = 1'b0; x = '0; y = '0;
    repeat (3) step();
    check("rst_rgb",   {a_r, a_g, a_b}, 12'h000);
    check("rst_hs",    a_hs, 1'b1);
    check("rst_vs",    a_vs, 1'b1);
    check("rst_ft",    a_ft, 1'b0);
    check("rst_cnt",   a_cnt, 8'd0);
    check("rst_boxxy", {u_dut.box_x_q, u_dut.box_y_q}, {10'd0, 9'd0});

    // Two-cycle latency: pixel, hsync and vsync all launched in cycle t.
    rst = 1'b0;
    step();
    x = 10'd5; y = 9'd5; blanking_in = 1'b0; hsync_in = 1'b0; vsync_in = 1'b0;
    step();
    blanking_in = 1'b1; hsync_in = 1'b1; vsync_in = 1'b1;
    check("lat_t1_rgb", {a_r, a_g, a_b}, 12'h000);
    check("lat_t1_hs",  a_hs, 1'b1);
    check("lat_t1_vs",  a_vs, 1'b1);
    check("lat_t1_ft",  a_ft, 1'b1);
    step();
    check("lat_t2_rgb", {a_r, a_g, a_b}, 12'hF80);
    check("lat_t2_hs",  a_hs, 1'b0);
    check("lat_t2_vs",  a_vs, 1'b0);
    check("lat_t2_ft",  a_ft, 1'b0);
    step();
    check("lat_t3_rgb", {a_r, a_g, a_b}, 12'h000);
    check("lat_t3_hs",  a_hs, 1'b1);
    check("lat_t3_vs",  a_vs, 1'b1);

    // Box edges at (0..31, 0..31), background and blanking override.
    pixel(10'd31, 9'd31, 1'b0);   check("pix_in_corner", {a_r, a_g, a_b}, 12'hF80);
    pixel(10'd32, 9'd0, 1'b0);    check("pix_right_out", {a_r, a_g, a_b}, 12'h123);
    pixel(10'd0, 9'd32, 1'b0);    check("pix_below_out", {a_r, a_g, a_b}, 12'h123);
    pixel(10'd100, 9'd100, 1'b0); check("pix_bg",        {a_r, a_g, a_b}, 12'h123);
    pixel(10'd5, 9'd5, 1'b1);     check("pix_blank",     {a_r, a_g, a_b}, 12'h000);

    // Disabled motion: ticks still pulse once each, held-low vsync is quiet.
    repeat (3) do_tick(1'b1);
    repeat (3) begin
      step();
      check("ft_held_low", a_ft, 1'b0);
    end
    check("en0_box", {u_dut.box_x_q, u_dut.box_y_q}, {10'd0, 9'd0});
    check("en0_cnt", a_cnt, 8'd0);

    // Enabled motion, 458 ticks: corner box one tick away from (400,240) corner.
    en = 1'b1;
    repeat (458) do_tick(1'b0);
    check("c458_box", {u_corner.box_x_q, u_corner.box_y_q}, {10'd390, 9'd240});
    check("c458_cnt", c_cnt, 8'd42);
    check("a458_box", {u_dut.box_x_q, u_dut.box_y_q}, {10'd458, 9'd439});
    check("a458_cnt", a_cnt, 8'd1);

    do_tick(1'b0);
    check("corner_box", {u_corner.box_x_q, u_corner.box_y_q}, {10'd400, 9'd240});
    check("corner_cnt", c_cnt, 8'd43);
    pixel(10'd450, 9'd300, 1'b0);
    check("corner_color", {c_r, c_g, c_b}, 12'hFFF);

    do_tick(1'b0);
    check("corner_dir_ul", {u_corner.box_x_q, u_corner.box_y_q}, {10'd385, 9'd225});
    check("corner_cnt_hold", c_cnt, 8'd43);

    // Default box: x reaches 607 on tick 607, pins at 608, bounces on 609.
    repeat (147) do_tick(1'b0);
    check("a607_box", {u_dut.box_x_q, u_dut.box_y_q}, {10'd607, 9'd290});
    check("a607_cnt", a_cnt, 8'd1);
    do_tick(1'b0);
    check("a608_box", {u_dut.box_x_q, u_dut.box_y_q}, {10'd608, 9'd289});
    check("a608_cnt", a_cnt, 8'd1);
    do_tick(1'b0);
    check("a609_box", {u_dut.box_x_q, u_dut.box_y_q}, {10'd608, 9'd288});
    check("a609_cnt", a_cnt, 8'd2);
    do_tick(1'b0);
    check("a610_left", {u_dut.box_x_q, u_dut.box_y_q}, {10'd607, 9'd287});
    pixel(10'd620, 9'd300, 1'b0);
    check("a610_color", {a_r, a_g, a_b}, 12'h08F);

    // Reset mid-line with the box being drawn.
    rst = 1'b1; hsync_in = 1'b0;
    step();
    check("mrst_rgb", {a_r, a_g, a_b}, 12'h000);
    check("mrst_hs",  a_hs, 1'b1);
    check("mrst_vs",  a_vs, 1'b1);
    check("mrst_ft",  a_ft, 1'b0);
    check("mrst_cnt", a_cnt, 8'd0);
    check("mrst_box", {u_dut.box_x_q, u_dut.box_y_q}, {10'd0, 9'd0});
    rst = 1'b0; hsync_in = 1'b1;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
